// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM sequencer.
//   pwm_state_e : sequencer state (IDLE: no active config, RUN: waveform running)
//   PWM_DEF_W   : default width of counter, period and duty fields
package pwm_pkg;

  localparam int unsigned PWM_DEF_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_e;

endpackage

// File: rtl/pwm_cfg_slot.sv
// One-entry valid/ready configuration buffer with a bypass output.
//   clk, rst   : clock, asynchronous active-low reset
//   i_valid    : configuration offered upstream
//   o_ready    : slot empty, offer is accepted this cycle
//   i_data     : offered configuration word
//   i_take     : consumer loads o_data this cycle (stored entry or bypassed offer)
//   o_pend     : a stored entry is waiting
//   o_valid    : stored entry or a same-cycle offer is available
//   o_data     : stored entry if present, otherwise the offered word
module pwm_cfg_slot #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  input  logic         i_take,
  output logic         o_pend,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_accept;

  assign o_ready  = ~r_valid;
  assign w_accept = i_valid & ~r_valid;
  assign o_pend   = r_valid;
  // An empty slot forwards the offer so a consumer can take it in the same cycle.
  assign o_valid  = r_valid | i_valid;
  assign o_data   = r_valid ? r_data : i_data;

  // A take always leaves the slot empty; a bypassed offer is never stored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_take) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

endmodule

// File: rtl/pwm_sequencer.sv
// PWM sequencer: tick-driven period counter with a one-entry config slot.
//   clk, rst        : clock, asynchronous active-low reset
//   ena             : global enable, low freezes counter and boundary logic
//   tick            : one counter step per strobe
//   cfg_valid/ready : configuration handshake (accepted regardless of ena)
//   cfg_period      : last counter value of a period (length cfg_period+1 ticks)
//   cfg_duty        : ticks per period with out high
//   out             : PWM waveform, combinational from state/counter/duty
//   period_done     : one-cycle pulse following each period wrap
// Build option: define PWM_RAMP_EN to ramp the active duty by one per boundary
// toward a newly applied duty instead of switching in one step.
module pwm_sequencer
  import pwm_pkg::*;
#(
  parameter int unsigned N = PWM_DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         tick,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [N-1:0] cfg_period,
  input  logic [N-1:0] cfg_duty,
  output logic         out,
  output logic         period_done
);

  pwm_state_e   r_state, w_state_nxt;
  logic [N-1:0] r_cnt, w_cnt_nxt;
  logic [N-1:0] r_period, w_period_nxt;
  logic [N-1:0] r_duty, w_duty_nxt;
  logic         r_pd;
`ifdef PWM_RAMP_EN
  logic [N-1:0] r_target, w_target_nxt;
`endif

  logic           w_take;
  logic           w_slot_pend;
  logic           w_slot_valid;
  logic [2*N-1:0] w_slot_data;
  logic [N-1:0]   w_new_period;
  logic [N-1:0]   w_new_duty;
  logic           w_boundary;

  pwm_cfg_slot #(
    .W(2 * N)
  ) u_slot (
    .clk    (clk),
    .rst    (rst),
    .i_valid(cfg_valid),
    .o_ready(cfg_ready),
    .i_data ({cfg_period, cfg_duty}),
    .i_take (w_take),
    .o_pend (w_slot_pend),
    .o_valid(w_slot_valid),
    .o_data (w_slot_data)
  );

  assign w_new_period = w_slot_data[2*N-1:N];
  assign w_new_duty   = w_slot_data[N-1:0];
  assign w_boundary   = (r_state == RUN) && ena && tick && (r_cnt == r_period);
  assign out          = (r_state == RUN) && (r_cnt < r_duty);
  assign period_done  = r_pd;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state, counter and config application.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_period_nxt = r_period;
    w_duty_nxt   = r_duty;
    w_take       = 1'b0;
`ifdef PWM_RAMP_EN
    w_target_nxt = r_target;
`endif
    case (r_state)
      IDLE: begin
        if (w_slot_pend) begin
          w_take       = 1'b1;
          w_state_nxt  = RUN;
          w_cnt_nxt    = '0;
          w_period_nxt = w_new_period;
`ifdef PWM_RAMP_EN
          w_duty_nxt   = '0;
          w_target_nxt = w_new_duty;
`else
          w_duty_nxt   = w_new_duty;
`endif
        end
      end
      RUN: begin
        if (w_boundary) begin
          w_cnt_nxt = '0;
          // Pending entry, or an offer arriving this very cycle, applies here.
          if (w_slot_valid) begin
            w_take       = 1'b1;
            w_period_nxt = w_new_period;
`ifdef PWM_RAMP_EN
            w_target_nxt = w_new_duty;
`else
            w_duty_nxt   = w_new_duty;
`endif
          end
`ifdef PWM_RAMP_EN
          // Step one unit toward the (possibly just updated) target.
          if (r_duty < w_target_nxt)      w_duty_nxt = r_duty + N'(1);
          else if (r_duty > w_target_nxt) w_duty_nxt = r_duty - N'(1);
`endif
        end else if (ena && tick) begin
          w_cnt_nxt = r_cnt + N'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_period <= '0;
      r_duty   <= '0;
      r_pd     <= 1'b0;
`ifdef PWM_RAMP_EN
      r_target <= '0;
`endif
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_period <= w_period_nxt;
      r_duty   <= w_duty_nxt;
      r_pd     <= w_boundary;
`ifdef PWM_RAMP_EN
      r_target <= w_target_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed bench for pwm_sequencer; inputs change just after the falling edge,
// outputs are sampled on the falling edge.
module tb_pwm_sequencer;

  localparam int unsigned N = 8;

  logic         clk;
  logic         rst;
  logic         ena;
  logic         tick;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [N-1:0] cfg_period;
  logic [N-1:0] cfg_duty;
  logic         out;
  logic         period_done;

  int errors = 0;
  int checks = 0;

  pwm_sequencer #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .tick       (tick),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .out        (out),
    .period_done(period_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    cfg_valid = 1'b0;
    #1;
    check("rst_out", out, 1'b0);
    check("rst_ready", cfg_ready, 1'b1);
    check("rst_pd", period_done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Offer a config from IDLE; returns at the first falling edge with counter=0.
  task automatic start_cfg(input logic [N-1:0] p, input logic [N-1:0] d);
    cfg_valid  = 1'b1;
    cfg_period = p;
    cfg_duty   = d;
    @(negedge clk);
    check("start_held", cfg_ready, 1'b0);
    cfg_valid = 1'b0;
    @(negedge clk);
  endtask

  // Steady-state waveform check with tick every cycle from counter=0.
  task automatic run_check(input string tag, input int p, input int d, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      check({tag, "_out"}, out, (k % (p + 1)) < d);
      check({tag, "_pd"}, period_done, (k > 0) && ((k % (p + 1)) == 0));
      @(negedge clk);
    end
  endtask

  initial begin
    rst        = 1'b1;
    ena        = 1'b0;
    tick       = 1'b0;
    cfg_valid  = 1'b0;
    cfg_period = '0;
    cfg_duty   = '0;
    #1 rst = 1'b0;
    #1;
    check("init_out", out, 1'b0);
    check("init_ready", cfg_ready, 1'b1);
    check("init_pd", period_done, 1'b0);
    @(negedge clk);
    rst  = 1'b1;
    ena  = 1'b1;
    tick = 1'b1;

    // Basic 4/2 waveform: 1,1,0,0,0 with a wrap pulse every 5 cycles.
    do_reset();
    start_cfg(8'd4, 8'd2);
    run_check("p4d2", 4, 2, 12);

    // Back-to-back configs, then a config offered on the boundary cycle.
    do_reset();
    cfg_valid = 1'b1; cfg_period = 8'd4; cfg_duty = 8'd2;
    @(negedge clk);
    check("b2b_ready_full", cfg_ready, 1'b0);
    check("b2b_idle_out", out, 1'b0);
    cfg_period = 8'd9; cfg_duty = 8'd3;
    @(negedge clk);
    check("b2b_run_out", out, 1'b1);
    check("b2b_ready_free", cfg_ready, 1'b1);
    @(negedge clk);
    check("b2b_second_held", cfg_ready, 1'b0);
    check("b2b_cnt1_out", out, 1'b1);
    cfg_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b2b_wait_ready", cfg_ready, 1'b0);
      check("b2b_wait_out", out, 1'b0);
      check("b2b_wait_pd", period_done, 1'b0);
    end
    @(negedge clk);
    check("b2b_wrap_pd", period_done, 1'b1);
    check("b2b_wrap_ready", cfg_ready, 1'b1);
    check("b2b_wrap_out", out, 1'b1);
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      check("p9d3_out", out, k < 3);
      check("p9d3_pd", period_done, 1'b0);
    end
    cfg_valid = 1'b1; cfg_period = 8'd4; cfg_duty = 8'd1;
    @(negedge clk);
    check("byp_pd", period_done, 1'b1);
    check("byp_ready", cfg_ready, 1'b1);
    check("byp_out", out, 1'b1);
    cfg_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("p4d1_out", out, (k % 5) == 0);
      check("p4d1_pd", period_done, (k % 5) == 0);
    end

    // Duty extremes and a zero-length period.
    do_reset();
    start_cfg(8'd5, 8'd0);
    run_check("d0", 5, 0, 13);
    do_reset();
    start_cfg(8'd5, 8'd7);
    run_check("d7", 5, 7, 13);
    do_reset();
    start_cfg(8'd0, 8'd1);
    run_check("p0", 0, 1, 5);

    // Freeze at counter=4 (next step would drop out) with ticks still present.
    do_reset();
    start_cfg(8'd9, 8'd5);
    for (int k = 1; k <= 4; k++) @(negedge clk);
    check("frz_pre_out", out, 1'b1);
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("frz_out", out, 1'b1);
      check("frz_pd", period_done, 1'b0);
    end
    ena = 1'b1;
    @(negedge clk);
    check("frz_resume_out", out, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("frz_tail_out", out, 1'b0);
      check("frz_tail_pd", period_done, 1'b0);
    end
    @(negedge clk);
    check("frz_wrap_pd", period_done, 1'b1);
    check("frz_wrap_out", out, 1'b1);

    // Reset at counter=3 with a pending config in the slot.
    do_reset();
    start_cfg(8'd9, 8'd5);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_period = 8'd7; cfg_duty = 8'd7;
    @(negedge clk);
    check("mid_pending", cfg_ready, 1'b0);
    cfg_valid = 1'b0;
    @(negedge clk);
    check("mid_cnt3_out", out, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_out", out, 1'b0);
    check("mid_rst_ready", cfg_ready, 1'b1);
    check("mid_rst_pd", period_done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_out", out, 1'b0);
      check("post_rst_ready", cfg_ready, 1'b1);
      check("post_rst_pd", period_done, 1'b0);
    end

    // Duty change 0 -> 3 on period 3: ramps one step per period when enabled.
    do_reset();
    start_cfg(8'd3, 8'd0);
    cfg_valid = 1'b1; cfg_period = 8'd3; cfg_duty = 8'd3;
    for (int k = 0; k < 20; k++) begin
      int dp;
      if (k == 1) cfg_valid = 1'b0;
`ifdef PWM_RAMP_EN
      dp = (k / 4 > 3) ? 3 : k / 4;
`else
      dp = (k < 4) ? 0 : 3;
`endif
      check("duty_chg_out", out, (k % 4) < dp);
      check("duty_chg_pd", period_done, (k > 0) && ((k % 4) == 0));
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_sequencer.md
PWM_SEQUENCER -- requirements
Module: pwm_sequencer

Interface
REQ-001 Parameter N, default 8: width of the tick counter, period and duty fields.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 ena  input  1  global enable; low freezes counter, output and boundary logic.
REQ-005 tick  input  1  one-cycle strobe from the upstream pulse_generator; one counter step per strobe.
REQ-006 cfg_valid  input  1  new configuration offered.
REQ-007 cfg_ready  output  1  configuration slot free.
REQ-008 cfg_period  input  N  last counter value of a PWM period (period length = cfg_period+1 ticks).
REQ-009 cfg_duty  input  N  number of ticks per period that out is high.
REQ-010 out  output  1  PWM waveform.
REQ-011 period_done  output  1  one-cycle pulse at each period wrap.

Function
REQ-012 The block SHALL implement states IDLE (no config active, out=0) and RUN.
REQ-013 A config SHALL be accepted on a cycle with cfg_valid && cfg_ready, independent of ena.
REQ-014 Accepted config SHALL go to a one-entry pending slot; cfg_ready SHALL be low while the slot is full.
REQ-015 In IDLE, a pending config SHALL become active on the next cycle, counter=0, state->RUN.
REQ-016 In RUN, the counter SHALL advance by 1 only on cycles with ena && tick.
REQ-017 Boundary: ena && tick && counter==active_period SHALL set counter=0, pulse period_done for exactly that next cycle, and apply any pending config.
REQ-018 A config accepted in the same cycle as a boundary SHALL bypass the slot and be active after that boundary; the slot stays empty.
REQ-019 out SHALL be combinational: (state==RUN) && (counter < active_duty).
REQ-020 cfg_duty=0 SHALL give out constantly low; cfg_duty>cfg_period SHALL give out constantly high.
REQ-021 cfg_period=0 SHALL make every qualified tick a boundary.
REQ-022 Counter arithmetic SHALL be N-bit unsigned; counter never exceeds active_period, so no wrap beyond it.
REQ-023 ena low SHALL hold counter, active config and out; period_done SHALL be 0.
REQ-024 tick without ena SHALL be ignored.

Reset
REQ-025 rst low SHALL immediately force state=IDLE, counter=0, active and pending config=0, slot empty, out=0, period_done=0, cfg_ready=1.
REQ-026 Reset mid-period SHALL discard the active and pending configs; no period_done is emitted.

Configuration
REQ-027 Macro PWM_RAMP_EN: when defined, a newly applied duty SHALL become the target, and active_duty SHALL step by 1 toward it at each boundary until equal; period is applied immediately.
REQ-028 Without PWM_RAMP_EN, active_duty SHALL take the new duty at the boundary in a single step.
REQ-029 With PWM_RAMP_EN, ramping from IDLE SHALL start at active_duty=0.

Structure
REQ-030 Package pwm_pkg SHALL hold the state enum (IDLE, RUN) and the default width constant.
REQ-031 The pending slot SHALL be sub-module pwm_cfg_slot (one-entry valid/ready buffer with bypass output).

Verification
REQ-032 Reset, then cfg period=4 duty=2, tick every cycle -> out pattern 1,1,0,0,0 repeating; period_done every 5 cycles.
REQ-033 Two configs back-to-back (4/2 then 9/3) -> second held with cfg_ready=0 until the first boundary, then period 10, out high 3 ticks.
REQ-034 duty=0 and duty=7 with period=5 -> out always 0 / always 1; period_done every 6 ticks.
REQ-035 ena low for 10 cycles mid-period with ticks present -> counter and out frozen; resumes at the same counter value.
REQ-036 rst asserted when counter=3 -> out=0, cfg_ready=1 same cycle, IDLE; no output until a new config.
REQ-037 PWM_RAMP_EN, period=3, duty 0->3 -> high time 1,2,3 ticks over successive periods.
